// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-FF synchroniser with a registered previous value for edge detection.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   vld_pipe;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= {SYNC_STAGES{RST_VAL}};
            prev_q   <= RST_VAL;
            vld_pipe <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q   <= sync_q[SYNC_STAGES-1];
            vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the chain holds real samples, so a pin that
    // already sits away from RST_VAL at reset release is not seen as an edge.
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = vld_pipe[SYNC_STAGES] &  level_o & ~prev_q;
    assign fall_o  = vld_pipe[SYNC_STAGES] & ~level_o &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, all four CPOL/CPHA modes, oversampled in the clk_i domain.
// Define SPI_SLAVE_UNDERRUN_EN to add the sticky underrun_o flag and its clear.
module spi_slave
    import spi_pkg::*;
#(
    parameter int             DW        = 8,
    parameter logic [DW-1:0]  IDLE_FILL = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cpol_i,
    input  logic          cpha_i,
    input  logic [DW-1:0] tx_data_i,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    output logic [DW-1:0] rx_data_o,
    output logic          rx_valid_o,
    output logic          busy_o,
    input  logic          sclk_i,
    input  logic          ss_ni,
    input  logic          mosi_i,
    output logic          miso_o,
    output logic          miso_oe_o
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic          underrun_o,
    input  logic          underrun_clr_i
`endif
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

    // index 0: sclk, 1: ss, 2: mosi
    localparam logic [2:0] SYNC_RST = 3'b010;

    logic [2:0] pin_raw, pin_lvl, pin_rise, pin_fall;

    assign pin_raw = {mosi_i, ss_ni, sclk_i};

    for (genvar g = 0; g < 3; g++) begin : g_sync
        spi_sync_edge #(.RST_VAL(SYNC_RST[g])) u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (pin_raw[g]),
            .level_o(pin_lvl[g]),
            .rise_o (pin_rise[g]),
            .fall_o (pin_fall[g])
        );
    end

    logic unused_mosi_edges;
    assign unused_mosi_edges = pin_rise[2] ^ pin_fall[2];

    logic sclk_lvl, sclk_edge, ss_lvl, ss_rise, ss_fall, mosi_lvl;
    assign sclk_lvl  = pin_lvl[0];
    assign sclk_edge = pin_rise[0] | pin_fall[0];
    assign ss_lvl    = pin_lvl[1];
    assign ss_rise   = pin_rise[1];
    assign ss_fall   = pin_fall[1];
    assign mosi_lvl  = pin_lvl[2];

    state_t        state;
    spi_mode_t     mode;
    logic [CW-1:0] bit_cnt;
    logic [DW-1:0] shift_reg, rx_shift, tx_buf;
    logic          tx_full;

    logic active, lead_edge, trail_edge, sample_edge, shift_edge, tx_load;
    logic [DW-1:0] rx_next;

    // After an edge the synchronised level equals the new clock level, so the
    // leading edge is the one that leaves the idle (cpol) level.
    assign active      = (state == XFER) && !ss_lvl;
    assign lead_edge   = active && sclk_edge && (sclk_lvl != mode.cpol);
    assign trail_edge  = active && sclk_edge && (sclk_lvl == mode.cpol);
    assign sample_edge = mode.cpha ? trail_edge : lead_edge;
    assign shift_edge  = mode.cpha ? lead_edge  : trail_edge;
    assign tx_load     = ((state == IDLE) && ss_fall && !cpha_i) ||
                         (shift_edge && (bit_cnt == '0));
    assign rx_next     = {rx_shift[DW-2:0], mosi_lvl};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            mode       <= '0;
            bit_cnt    <= '0;
            busy_o     <= 1'b0;
            miso_oe_o  <= 1'b0;
            shift_reg  <= '0;
            rx_shift   <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            tx_buf     <= '0;
            tx_full    <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;

            if (tx_load) begin
                shift_reg <= tx_full ? tx_buf : IDLE_FILL;
                tx_full   <= 1'b0;
            end else if (shift_edge) begin
                shift_reg <= {shift_reg[DW-2:0], 1'b0};
            end

            // A capture in the same cycle as a load wins: buffer stays full.
            if (tx_valid_i && !tx_full) begin
                tx_buf  <= tx_data_i;
                tx_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state     <= XFER;
                        mode      <= '{cpol: cpol_i, cpha: cpha_i};
                        bit_cnt   <= '0;
                        busy_o    <= 1'b1;
                        miso_oe_o <= 1'b1;
                    end
                end
                XFER: begin
                    if (ss_rise) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        busy_o    <= 1'b0;
                        miso_oe_o <= 1'b0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            rx_data_o  <= rx_next;
                            rx_valid_o <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_ready_o = !tx_full;
    assign miso_o     = shift_reg[DW-1];

`ifdef SPI_SLAVE_UNDERRUN_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            underrun_o <= 1'b0;
        else if (tx_load && !tx_full)
            underrun_o <= 1'b1;
        else if (underrun_clr_i)
            underrun_o <= 1'b0;
    end
`endif

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder: the far end of the link driven by the team's SPI master.
- Oversamples sclk_i, ss_ni and mosi_i in the system clock domain.
- Shifts a transmit byte out on miso_o and assembles a receive byte from mosi_i.
- Supports all four CPOL/CPHA modes; frames may carry back-to-back words while ss_ni stays low.
- Sits between a user-side data port (valid/ready TX, pulsed RX) and the external SPI pins.

Parameters:
- DW, 8, data word width in bits (>= 2).
- IDLE_FILL, {DW{1'b0}}, word shifted out when no TX data is buffered.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cpol_i  in  1  clock polarity; latched at frame start.
- cpha_i  in  1  clock phase; latched at frame start.
- tx_data_i  in  DW  next word to transmit.
- tx_valid_i  in  1  tx_data_i valid.
- tx_ready_o  out  1  TX holding buffer empty.
- rx_data_o  out  DW  last complete received word.
- rx_valid_o  out  1  one-cycle pulse, rx_data_o updated.
- busy_o  out  1  frame in progress.
- sclk_i  in  1  SPI clock from master (asynchronous).
- ss_ni  in  1  slave select, active-low (asynchronous).
- mosi_i  in  1  serial data in.
- miso_o  out  1  serial data out (MSB first).
- miso_oe_o  out  1  miso driver enable.

Behaviour:
- Clock ratio: clk_i must be >= 4x sclk_i. With the same clock feeding the master, master dvsr_i >= 1.
- Synchronisation: sclk_i, ss_ni and mosi_i pass through 2-FF synchronisers plus one edge-detect register, giving 3 clk_i of latency.
  - Sync reset values: ss = 1, sclk = 0, mosi = 0.
  - sclk edges are ignored while synchronised ss is high.
- Edge definitions:
  - Leading edge = rising if cpol = 0, falling if cpol = 1.
  - Sample edge = leading if cpha = 0, trailing if cpha = 1.
  - Shift edge = the other edge.
- FSM states: IDLE, XFER.
  - IDLE->XFER on synchronised ss falling edge: latch cpol/cpha, bit_cnt = 0, busy_o = 1, miso_oe_o = 1.
  - XFER->IDLE on synchronised ss rising edge: busy_o = 0, miso_oe_o = 0, bit_cnt = 0.
- TX load point:
  - cpha = 0: shift register loads at ss fall, then on each shift edge where bit_cnt == 0.
  - cpha = 1: shift register loads on each leading edge where bit_cnt == 0.
  - Load source: TX buffer if full (buffer empties, tx_ready_o rises the next cycle), otherwise IDLE_FILL.
- TX shifting: on all other shift edges the register shifts left. miso_o = shift_reg[DW-1] at all times.
- RX: on each sample edge, mosi is shifted into rx_shift and bit_cnt increments, wrapping DW-1 -> 0.
  - At the wrap, rx_data_o <= completed word and rx_valid_o pulses for 1 cycle.
- TX buffer handshake:
  - tx_valid_i && tx_ready_o captures tx_data_i.
  - Simultaneous load and capture in the same cycle is allowed; the buffer stays full with the new word.
- ss rising mid-word aborts the word:
  - partial RX is discarded and no rx_valid_o is issued;
  - a TX word already loaded is consumed and not retransmitted.
- Reset values: tx_ready_o = 1, rx_data_o = 0, rx_valid_o = 0, busy_o = 0, miso_o = 0, miso_oe_o = 0, FSM = IDLE.
  - Reset mid-frame drops everything.
  - After reset, the next frame begins only on a fresh ss falling edge.

Optional Feature:
- Macro: SPI_SLAVE_UNDERRUN_EN.
- Defined: adds ports underrun_o (out, 1) and underrun_clr_i (in, 1).
  - underrun_o is a sticky flag, set the cycle after any IDLE_FILL load.
  - It is cleared by underrun_clr_i; set has priority over clear.
  - Reset value 0.
- Undefined: ports absent; IDLE_FILL loads are silent.

Decomposition:
- spi_pkg holds:
  - state enum (IDLE, XFER);
  - spi_mode_t struct {cpol, cpha};
  - SYNC_STAGES = 2.
- Sub-module spi_sync_edge: synchroniser plus edge detector, instantiated for sclk, ss and mosi. Outputs level, rise and fall.

Test Plan:
- Mode 0, master dvsr 3, master din 0xA5, slave TX 0x3C, ss_ni low around start: master dout = 0x3C, slave rx_data_o = 0xA5, exactly one rx_valid_o pulse.
- Repeat for modes 1, 2 and 3 with master 0x5A / slave 0xC3: both sides receive the correct word in every mode.
- Empty TX buffer, master sends 0xFF: master receives 0x00. underrun_o = 1 with SPI_SLAVE_UNDERRUN_EN defined, then underrun_clr_i clears it.
- ss_ni held low for two words: slave TX 0x11 then 0x22 (second written while tx_ready_o = 1 mid-frame), master sends 0x81, 0x42. Master receives 0x11, 0x22; slave receives 0x81, 0x42.
- ss_ni raised after 4 bits: no rx_valid_o, busy_o = 0. The next full frame receives the correct word.
- rst_ni asserted mid-frame: all outputs return to reset values. The following frame works normally.
